uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receive deserializer for the UART peripheral. Consumes the 16x oversampling enable produced by the datapath's configurable sample clock counter, detects and validates start bits, and shifts in 5-8 data bits LSB-first. Checks optional parity and 1 or 2 stop bits, then writes the completed character into the RX queue. Reports parity, framing and overrun errors alongside each character.

Parameters:
OVERSAMPLE, 16, sample_en ticks per bit; fixed at 16, other values unsupported
SYNC_STAGES, 2, flip-flops in the rx input synchronizer (min 2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
sample_en  input  1  one-clk pulse per oversample tick (16 per bit)
rx  input  1  asynchronous serial line, idle high
data_bits_count  input  2  data bits = value + 5 (5..8)
parity_type  input  2  [0]=parity enable, [1]=odd (1) / even (0)
double_stop_bits  input  1  1 = two stop bits expected
queue_full  input  1  RX queue full
overrun_clr  input  1  clears sticky overrun flag
dout  output  8  received character, right-aligned, unused upper bits 0
dout_valid  output  1  one-clk write strobe to RX queue
parity_err  output  1  parity error of current dout; valid with dout_valid
frame_err  output  1  stop-bit error of current dout; valid with dout_valid
overrun  output  1  sticky: character dropped because queue_full
busy  output  1  high in any state except IDLE

Behaviour:
- Clocking and reset: single clock; reset is synchronous and active-high, named clk/reset as elsewhere in the codebase.
- Reset values: all outputs 0, state IDLE, synchronizer flops 1, armed 0.
- Timing base:
  - rx passes through SYNC_STAGES flops each clk; "line" means the synchronized value.
  - All state changes occur only on clk edges where sample_en=1 ("ticks").
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- Tick counter: 4-bit, increments per tick outside IDLE, wraps 15->0. Tick 15 = bit end, advances state.
- Bit decision: each bit's value is decided at tick 8 of that bit (see Optional Feature).
- IDLE:
  - A tick with line=1 sets armed.
  - A tick with armed=1 and line=0 -> START; counter=0; armed cleared.
  - Config inputs are latched at this moment. Config changes mid-frame have no effect until the next frame.
- START:
  - Decided value 1 at tick 8 = false start -> IDLE; nothing reported.
  - Decided value 0 -> continue; at tick 15 -> DATA.
- DATA:
  - Decided bit shifts into the MSB side of an 8-bit register (LSB-first line order).
  - After N bits (N = latched count+5) -> PARITY if parity enabled, else STOP1.
  - On completion the character is right-shifted by 8-N so it is right-aligned.
- PARITY:
  - Received bit is XORed with the running XOR of the data bits.
  - Even mode: error if result is 1. Odd mode: error if result is 0.
- STOP1:
  - Decided 0 -> frame error.
  - If double_stop_bits -> STOP2 at tick 15. Otherwise the frame completes at tick 8.
- STOP2: same check as STOP1; frame completes at tick 8.
- Completion (frame end at tick 8):
  - Return to IDLE immediately, so the next start edge can resync.
  - armed = decided stop value.
  - In the following clk cycle: if queue_full=0, pulse dout_valid for exactly 1 clk with dout/parity_err/frame_err. If queue_full=1, no strobe and overrun<=1.
  - dout/parity_err/frame_err hold until the next completion.
- overrun: cleared by overrun_clr; if set and clear coincide, set wins.
- Reset mid-frame: abort the frame, no strobe, outputs return to reset values.
- A line held low (break) produces one character with frame_err=1, then no further starts until the line returns high.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: bit value = majority of line samples at ticks 6, 7, 8; decision still at tick 8.
- Undefined: bit value = line sample at tick 8 only.
- Latency is identical in both builds.

Test Plan:
- Tick timing: sample_en=1 every clk unless stated.
- 8N1: config 3/00/0, send 0xA5 -> exactly one dout_valid, dout=0xA5, parity_err=0, frame_err=0, ≈9.5 bit times after the start edge.
- 7E1: config 2/01/0, send 0x35 with parity bit 1 (correct is 0) -> dout=0x35, parity_err=1. Repeat with 0x35 odd parity and bit 1 -> parity_err=0.
- 5N2: config 0/00/1, send 0x1F with second stop bit 0 -> dout=0x1F, frame_err=1; next frame 0x0A clean -> frame_err=0.
- False start: line low for 4 ticks on an idle line -> no dout_valid, busy falls by tick 8.
- Overrun: queue_full=1 at completion of 0x42 -> no dout_valid, overrun=1. overrun_clr=1 for 1 clk -> overrun=0. overrun_clr coinciding with a new drop -> overrun stays 1.
- Majority: 1-tick low glitch at tick 8 of a data bit of 0xFF -> dout=0xFF with the macro defined, that bit reads 0 without it. A reset asserted mid-DATA -> busy=0, no strobe.

Source files
------------

// File: rtl/uart_rx_if.sv
// RX queue write port of the UART receiver: character, strobe, per-character error flags.
// Latency: none, plain signal bundle.
// Backpressure: queue_full from the queue side; the receiver drops rather than stalls.
interface uart_rx_if;
  logic [7:0] dout;
  logic       dout_valid;
  logic       parity_err;
  logic       frame_err;
  logic       queue_full;

  // receiver side: writes characters into the queue
  modport master (
    output dout,
    output dout_valid,
    output parity_err,
    output frame_err,
    input  queue_full
  );

  // queue side: accepts characters, reports fullness
  modport slave (
    input  dout,
    input  dout_valid,
    input  parity_err,
    input  frame_err,
    output queue_full
  );
endinterface

// File: rtl/uart_rx.sv
// UART receive deserializer: 16x oversampled start detect, 5-8 data bits LSB-first, optional parity, 1/2 stop bits.
// Latency: write strobe one clk after the frame-ending tick (mid final stop bit); optional UART_RX_MAJORITY_EN votes ticks 6/7/8.
// Backpressure: none; a character completing while queue_full=1 is dropped and sets sticky overrun.
module uart_rx #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_en,
  input  logic       rx,
  input  logic [1:0] data_bits_count,
  input  logic [1:0] parity_type,
  input  logic       double_stop_bits,
  input  logic       overrun_clr,
  output logic       overrun,
  output logic       busy,
  uart_rx_if.master  rxq
);

  // Bit timing within one bit period, measured in sample_en ticks.
  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   line;
  logic                   bit_d;

  state_t      state;
  logic [3:0]  cnt;
  logic        armed;

  // Frame configuration, frozen at the start edge.
  logic [1:0]  cfg_bits;
  logic        cfg_par_en;
  logic        cfg_par_odd;
  logic        cfg_dbl;

  logic [7:0]  shreg;
  logic [2:0]  bit_idx;
  logic        par_acc;
  logic        perr_r;
  logic        ferr_r;

  // Completed character waiting one clk for the queue write decision.
  logic        pend;
  logic [7:0]  pend_dat;
  logic        pend_perr;
  logic        pend_ferr;

  // Right shift that aligns an N-bit character to bit 0 (8-N = 3-count).
  logic [1:0]  shamt;
  assign shamt = 2'd3 - cfg_bits;

  // Metastability synchronizer; flops reset to the idle line level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx};
    end
  end

  assign line = sync[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  logic s_early;
  logic s_late;

  // Capture the two samples preceding the decision tick for a 2-of-3 vote.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_early <= 1'b1;
      s_late  <= 1'b1;
    end else if (sample_en && state != IDLE) begin
      if (cnt == MID_TICK - 4'd2) s_early <= line;
      if (cnt == MID_TICK - 4'd1) s_late  <= line;
    end
  end

  assign bit_d = (s_early & s_late) | (s_early & line) | (s_late & line);
`else
  assign bit_d = line;
`endif

  // Frame FSM: all state changes happen on sample ticks; pend is a one-clk pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      armed       <= 1'b0;
      busy        <= 1'b0;
      cfg_bits    <= 2'd0;
      cfg_par_en  <= 1'b0;
      cfg_par_odd <= 1'b0;
      cfg_dbl     <= 1'b0;
      shreg       <= 8'd0;
      bit_idx     <= 3'd0;
      par_acc     <= 1'b0;
      perr_r      <= 1'b0;
      ferr_r      <= 1'b0;
      pend        <= 1'b0;
      pend_dat    <= 8'd0;
      pend_perr   <= 1'b0;
      pend_ferr   <= 1'b0;
    end else begin
      pend <= 1'b0;
      if (sample_en) begin
        if (state != IDLE) cnt <= cnt + 4'd1;
        case (state)
          IDLE: begin
            // Only a high-to-low transition starts a frame, so a held-low
            // line cannot retrigger until it has been seen high again.
            if (line) begin
              armed <= 1'b1;
            end else if (armed) begin
              state       <= START;
              busy        <= 1'b1;
              cnt         <= 4'd0;
              armed       <= 1'b0;
              cfg_bits    <= data_bits_count;
              cfg_par_en  <= parity_type[0];
              cfg_par_odd <= parity_type[1];
              cfg_dbl     <= double_stop_bits;
              bit_idx     <= 3'd0;
              par_acc     <= 1'b0;
              perr_r      <= 1'b0;
              ferr_r      <= 1'b0;
            end
          end

          START: begin
            if (cnt == MID_TICK && bit_d) begin
              // Glitch, not a start bit: drop silently.
              state <= IDLE;
              busy  <= 1'b0;
              armed <= 1'b1;
            end else if (cnt == LAST_TICK) begin
              state <= DATA;
            end
          end

          DATA: begin
            if (cnt == MID_TICK) begin
              shreg   <= {bit_d, shreg[7:1]};
              par_acc <= par_acc ^ bit_d;
            end
            if (cnt == LAST_TICK) begin
              if (bit_idx == {1'b0, cfg_bits} + 3'd4) begin
                state <= cfg_par_en ? PARITY : STOP1;
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end
          end

          PARITY: begin
            if (cnt == MID_TICK) begin
              perr_r <= cfg_par_odd ? ~(par_acc ^ bit_d) : (par_acc ^ bit_d);
            end
            if (cnt == LAST_TICK) begin
              state <= STOP1;
            end
          end

          STOP1: begin
            if (cnt == MID_TICK) begin
              ferr_r <= ~bit_d;
              if (!cfg_dbl) begin
                // Finish mid stop bit so the next start edge is not missed.
                state     <= IDLE;
                busy      <= 1'b0;
                armed     <= bit_d;
                pend      <= 1'b1;
                pend_dat  <= shreg >> shamt;
                pend_perr <= perr_r;
                pend_ferr <= ~bit_d;
              end
            end else if (cnt == LAST_TICK && cfg_dbl) begin
              state <= STOP2;
            end
          end

          STOP2: begin
            if (cnt == MID_TICK) begin
              state     <= IDLE;
              busy      <= 1'b0;
              armed     <= bit_d;
              pend      <= 1'b1;
              pend_dat  <= shreg >> shamt;
              pend_perr <= perr_r;
              pend_ferr <= ferr_r | ~bit_d;
            end
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Queue write stage: strobe when there is room, otherwise record the drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxq.dout       <= 8'd0;
      rxq.dout_valid <= 1'b0;
      rxq.parity_err <= 1'b0;
      rxq.frame_err  <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      rxq.dout_valid <= 1'b0;
      if (pend) begin
        rxq.dout       <= pend_dat;
        rxq.parity_err <= pend_perr;
        rxq.frame_err  <= pend_ferr;
        rxq.dout_valid <= ~rxq.queue_full;
      end
      // A new drop takes priority over a simultaneous clear.
      if (pend && rxq.queue_full) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected characters, a monitor pops on each dout_valid.
// Latency: one bit = 16 clk (sample_en held high).
// Backpressure: queue_full driven directly to exercise the overrun path.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_en;
  logic       rx;
  logic [1:0] data_bits_count;
  logic [1:0] parity_type;
  logic       double_stop_bits;
  logic       overrun_clr;
  logic       overrun;
  logic       busy;

  uart_rx_if rxq_if ();

  uart_rx #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .sample_en        (sample_en),
    .rx               (rx),
    .data_bits_count  (data_bits_count),
    .parity_type      (parity_type),
    .double_stop_bits (double_stop_bits),
    .overrun_clr      (overrun_clr),
    .overrun          (overrun),
    .busy             (busy),
    .rxq              (rxq_if.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int strobe_cyc = -1;
  int strobe_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d  = d;
    e.pe = pe;
    e.fe = fe;
    sb.push_back(e);
  endtask

  // Monitor: every strobe must match the oldest expected character.
  always @(negedge clk) begin
    if (rxq_if.dout_valid === 1'b1) begin
      strobe_cyc = cyc;
      strobe_cnt++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe: got dout=0x%0h, expected no strobe (cycle %0d)",
                 rxq_if.dout, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("dout", {24'd0, rxq_if.dout}, {24'd0, mon_e.d});
        chk("parity_err", {31'd0, rxq_if.parity_err}, {31'd0, mon_e.pe});
        chk("frame_err", {31'd0, rxq_if.frame_err}, {31'd0, mon_e.fe});
      end
    end
  end

  // One bit period; a low glitch is forced at clk index g (none if g<0).
  task automatic drive_bit(input logic v, input int g);
    for (int i = 0; i < 16; i++) begin
      rx = (i == g) ? 1'b0 : v;
      @(negedge clk);
    end
  endtask

  // Full frame, called just after a negedge; glitch_bit selects a data bit
  // whose tick-8 sample is forced low for one clk.
  task automatic send_frame(input logic [7:0] data, input int nbits, input logic par_en,
                            input logic par_bit, input int nstop, input logic stop2_val,
                            input int glitch_bit);
    drive_bit(1'b0, -1);
    for (int j = 0; j < nbits; j++) begin
      drive_bit(data[j], (j == glitch_bit) ? 9 : -1);
    end
    if (par_en) drive_bit(par_bit, -1);
    drive_bit(1'b1, -1);
    if (nstop == 2) drive_bit(stop2_val, -1);
    rx = 1'b1;
    repeat (24) @(negedge clk);
  endtask

  logic [7:0] exp_maj;
  int t0;
  int c0;

  initial begin
    reset            = 1'b1;
    rx               = 1'b1;
    sample_en        = 1'b1;
    data_bits_count  = 2'd3;
    parity_type      = 2'b00;
    double_stop_bits = 1'b0;
    overrun_clr      = 1'b0;
    rxq_if.queue_full = 1'b0;
    repeat (4) @(negedge clk);

    // Reset state
    chk("rst_dout", {24'd0, rxq_if.dout}, 32'd0);
    chk("rst_dout_valid", {31'd0, rxq_if.dout_valid}, 32'd0);
    chk("rst_parity_err", {31'd0, rxq_if.parity_err}, 32'd0);
    chk("rst_frame_err", {31'd0, rxq_if.frame_err}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    // 8N1, 0xA5: one clean character, latency from start edge
    push_exp(8'hA5, 1'b0, 1'b0);
    t0 = cyc;
    c0 = strobe_cnt;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1, -1);
    chk("8n1_strobe_count", strobe_cnt - c0, 32'd1);
    chk("8n1_latency_clk", strobe_cyc - t0, 32'd157);

    // 7E1, 0x35 with wrong parity bit 1
    data_bits_count = 2'd2;
    parity_type     = 2'b01;
    push_exp(8'h35, 1'b1, 1'b0);
    send_frame(8'h35, 7, 1'b1, 1'b1, 1, 1'b1, -1);

    // 7O1, 0x35 with correct odd parity bit 1
    parity_type = 2'b11;
    push_exp(8'h35, 1'b0, 1'b0);
    send_frame(8'h35, 7, 1'b1, 1'b1, 1, 1'b1, -1);

    // 5N2, 0x1F with bad second stop bit, then clean 0x0A
    data_bits_count  = 2'd0;
    parity_type      = 2'b00;
    double_stop_bits = 1'b1;
    push_exp(8'h1F, 1'b0, 1'b1);
    send_frame(8'h1F, 5, 1'b0, 1'b0, 2, 1'b0, -1);
    push_exp(8'h0A, 1'b0, 1'b0);
    send_frame(8'h0A, 5, 1'b0, 1'b0, 2, 1'b1, -1);

    // False start: 4 clk low pulse
    data_bits_count  = 2'd3;
    double_stop_bits = 1'b0;
    c0 = strobe_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("false_start_busy_high", {31'd0, busy}, 32'd1);
    repeat (10) @(negedge clk);
    chk("false_start_busy_low", {31'd0, busy}, 32'd0);
    repeat (20) @(negedge clk);
    chk("false_start_no_strobe", strobe_cnt - c0, 32'd0);

    // Overrun: drop 0x42 while queue is full, then clear
    rxq_if.queue_full = 1'b1;
    c0 = strobe_cnt;
    send_frame(8'h42, 8, 1'b0, 1'b0, 1, 1'b1, -1);
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    chk("overrun_no_strobe", strobe_cnt - c0, 32'd0);
    rxq_if.queue_full = 1'b0;
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    @(negedge clk);
    chk("overrun_cleared", {31'd0, overrun}, 32'd0);

    // Clear coinciding with a new drop: set wins
    rxq_if.queue_full = 1'b1;
    fork
      send_frame(8'h42, 8, 1'b0, 1'b0, 1, 1'b1, -1);
      begin
        repeat (156) @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
      end
    join
    chk("overrun_set_wins", {31'd0, overrun}, 32'd1);
    rxq_if.queue_full = 1'b0;

    // Single-clk low glitch at tick 8 of data bit 3 of 0xFF
`ifdef UART_RX_MAJORITY_EN
    exp_maj = 8'hFF;
`else
    exp_maj = 8'hF7;
`endif
    push_exp(exp_maj, 1'b0, 1'b0);
    send_frame(8'hFF, 8, 1'b0, 1'b0, 1, 1'b1, 3);

    // Reset in the middle of DATA
    c0 = strobe_cnt;
    drive_bit(1'b0, -1);
    drive_bit(1'b1, -1);
    drive_bit(1'b1, -1);
    drive_bit(1'b1, -1);
    chk("mid_data_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_dout", {24'd0, rxq_if.dout}, 32'd0);
    chk("reset_overrun", {31'd0, overrun}, 32'd0);
    reset = 1'b0;
    rx = 1'b1;
    repeat (200) @(negedge clk);
    chk("reset_no_strobe", strobe_cnt - c0, 32'd0);
    chk("reset_idle_busy", {31'd0, busy}, 32'd0);

    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
